// File: rtl/sp_ram_arb_pkg.sv
// sp_ram_arb_pkg: shared types and sizes for the single-port RAM arbiter
package sp_ram_arb_pkg;
  localparam int RAM_AW = 12;
  localparam int RAM_DW = 8;
  typedef enum logic [2:0] {IDLE, ISSUE, RDWAIT, ACK, CLEAR} state_t;
  typedef enum logic {REQ_A, REQ_B} req_id_t;
endpackage

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: serialises two single-beat requesters onto a single-port RAM and runs a hardware fill
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_value,
  output logic          clr_busy,
  output logic          ram_ce,
  output logic          ram_wre,
  output logic          ram_oce,
  output logic          ram_reset,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  state_t      state;
  req_id_t     win;
  logic        we_r;
  logic [3:0]  starve;
  logic [AW:0] clr_cnt;
  logic [AW:0] clr_nxt;
  logic        b_wins;
  // B wins when A is idle or when A has been granted STARVE_LIMIT times in a row over a waiting B
  always_comb begin
    b_wins  = b_req && (!a_req || starve == 4'(STARVE_LIMIT));
    clr_nxt = clr_cnt + 1'b1;
  end
  assign ram_ce    = state == ISSUE || state == CLEAR;
  assign ram_wre   = state == CLEAR || (state == ISSUE && we_r);
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;
  assign clr_busy  = state == CLEAR;
  assign a_ack     = state == ACK && win == REQ_A;
  assign b_ack     = state == ACK && win == REQ_B;
  // Sequencer: grant, one-cycle RAM issue, optional read capture, ack; fill walks every address once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      win     <= REQ_A;
      we_r    <= 1'b0;
      starve  <= '0;
      clr_cnt <= '0;
      ram_ad  <= '0;
      ram_din <= '0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            clr_cnt <= '0;
            ram_ad  <= '0;
            ram_din <= clr_value;
            state   <= CLEAR;
          end else if (a_req || b_req) begin
            win     <= b_wins ? REQ_B : REQ_A;
            we_r    <= b_wins ? b_we : a_we;
            ram_ad  <= b_wins ? b_addr : a_addr;
            ram_din <= b_wins ? b_wdata : a_wdata;
            starve  <= b_wins ? '0 : (b_req && starve != 4'hf) ? starve + 4'd1 : starve;
            state   <= ISSUE;
          end
        end
        ISSUE: state <= we_r ? ACK : RDWAIT;
        RDWAIT: begin
          if (win == REQ_A) a_rdata <= ram_dout;
          else b_rdata <= ram_dout;
          state <= ACK;
        end
        ACK: state <= IDLE;
        CLEAR: begin
          clr_cnt <= clr_nxt;
          ram_ad  <= clr_nxt[AW] ? ram_ad : clr_nxt[AW-1:0];
          state   <= clr_nxt[AW] ? IDLE : CLEAR;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter: timeline-model checked bench for the single-port RAM arbiter
module tb_sp_ram_arbiter;
  localparam int LIM = 4;
  logic        clk = 0, reset_n = 1;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0, clr_start = 0;
  logic [11:0] a_addr = 0, b_addr = 0;
  logic [7:0]  a_wdata = 0, b_wdata = 0, clr_value = 0;
  logic        a_ack, b_ack, clr_busy, ram_ce, ram_wre, ram_oce, ram_reset;
  logic [7:0]  a_rdata, b_rdata, ram_din, ram_dout;
  logic [11:0] ram_ad;
  int tests = 0, fails = 0;

  sp_ram_arbiter #(.AW(12), .DW(8), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
    .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_oce(ram_oce), .ram_reset(ram_reset),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // RAM stand-in: registered output, write-through on writes
  logic [7:0] mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'hA5;
    ram_dout <= '0;
    forever begin
      @(posedge clk);
      if (ram_ce) begin
        if (ram_wre) begin
          mem[ram_ad] = ram_din;
          ram_dout <= ram_din;
        end else ram_dout <= mem[ram_ad];
      end
    end
  end

  // Timeline model: grants, ack cycles, fill windows and memory contents
  int cyc = 0, free_at = 0, ack_at = -1, issue_at = -1, busy_from = 1, busy_to = 0, st = 0;
  bit win_b = 0, cur_we = 0;
  logic [11:0] cur_addr = 0;
  logic [7:0] cur_wd = 0, cur_rd = 0, fill_val = 0;
  logic [7:0] ref_mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i) ^ 8'hA5;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        st = 0; free_at = 0; ack_at = -1; issue_at = -1; busy_from = 1; busy_to = 0;
      end else begin
        if (cyc >= busy_from && cyc <= busy_to) ref_mem[cyc - busy_from] = fill_val;
        if (cyc >= free_at) begin
          if (clr_start) begin
            busy_from = cyc + 1; busy_to = cyc + 4096; free_at = cyc + 4097; fill_val = clr_value;
          end else if (a_req || b_req) begin
            win_b = !a_req || (b_req && st == LIM);
            cur_we = win_b ? b_we : a_we;
            cur_addr = win_b ? b_addr : a_addr;
            cur_wd = win_b ? b_wdata : a_wdata;
            st = win_b ? 0 : (b_req && st < 15) ? st + 1 : st;
            if (cur_we) ref_mem[cur_addr] = cur_wd;
            cur_rd = ref_mem[cur_addr];
            issue_at = cyc + 1;
            ack_at = cyc + (cur_we ? 2 : 3);
            free_at = ack_at + 1;
          end
        end
        cyc++;
      end
    end
  end

  // Per-cycle comparison against the model
  logic [7:0] exp_a = 0, exp_b = 0;
  initial forever begin
    bit ea, eb, iss, bz;
    @(negedge clk);
    ea = reset_n && cyc == ack_at && !win_b;
    eb = reset_n && cyc == ack_at && win_b;
    iss = reset_n && cyc == issue_at;
    bz = reset_n && cyc >= busy_from && cyc <= busy_to;
    if (!reset_n) begin exp_a = 0; exp_b = 0; end
    if (ea && !cur_we) exp_a = cur_rd;
    if (eb && !cur_we) exp_b = cur_rd;
    chk("a_ack", a_ack, ea);
    chk("b_ack", b_ack, eb);
    chk("a_rdata", a_rdata, exp_a);
    chk("b_rdata", b_rdata, exp_b);
    chk("clr_busy", clr_busy, bz);
    chk("ram_ce", ram_ce, iss || bz);
    chk("ram_wre", ram_wre, (iss && cur_we) || bz);
    chk("ram_oce", ram_oce, 1);
    chk("ram_reset", ram_reset, 0);
    if (iss) chk("issue_ad", ram_ad, cur_addr);
    if (iss && cur_we) chk("issue_din", ram_din, cur_wd);
    if (bz) begin
      chk("fill_ad", ram_ad, cyc - busy_from);
      chk("fill_din", ram_din, fill_val);
    end
  end

  task automatic op(input bit pb, input bit we, input logic [11:0] ad, input logic [7:0] wd,
                    output int lat, output logic [7:0] rd);
    lat = 0;
    if (pb) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
    else begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
    do begin @(negedge clk); lat++; end while (!(pb ? b_ack : a_ack) && lat < 20);
    if (!(pb ? b_ack : a_ack)) chk("op_ack_timeout", 0, 1);
    rd = pb ? b_rdata : a_rdata;
    if (pb) b_req = 0; else a_req = 0;
  endtask

  task automatic reset_zero(input string tag);
    chk({tag, "_a_ack"}, a_ack, 0);
    chk({tag, "_b_ack"}, b_ack, 0);
    chk({tag, "_a_rdata"}, a_rdata, 0);
    chk({tag, "_b_rdata"}, b_rdata, 0);
    chk({tag, "_ram_ce"}, ram_ce, 0);
    chk({tag, "_ram_wre"}, ram_wre, 0);
    chk({tag, "_ram_ad"}, ram_ad, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
    chk({tag, "_clr_busy"}, clr_busy, 0);
  endtask

  int lat, ta, tb, na, nacks, a_before, n, k, bad;
  logic [7:0] rd, ra, rb;
  initial begin
    #1 reset_n = 0;
    @(posedge clk); #3;
    reset_zero("rst");
    @(negedge clk);
    @(negedge clk) reset_n = 1;
    @(negedge clk);
    // A write then read back
    op(0, 1, 12'h123, 8'h5A, lat, rd);
    chk("t1_wr_lat", lat, 2);
    @(negedge clk);
    op(0, 0, 12'h123, 8'h00, lat, rd);
    chk("t1_rd_lat", lat, 3);
    chk("t1_rd_data", rd, 8'h5A);
    // simultaneous reads
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 12'h010; b_req = 1; b_we = 0; b_addr = 12'h020;
    ta = -1; tb = -1; ra = 0; rb = 0;
    for (int i = 1; i <= 30 && (ta < 0 || tb < 0); i++) begin
      @(negedge clk);
      if (a_ack) begin ta = i; ra = a_rdata; a_req = 0; end
      if (b_ack) begin tb = i; rb = b_rdata; b_req = 0; end
    end
    a_req = 0; b_req = 0;
    chk("t2_a_lat", ta, 3);
    chk("t2_b_gap", tb - ta, 4);
    chk("t2_a_data", ra, 8'hB5);
    chk("t2_b_data", rb, 8'h85);
    // starvation limit
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 12'h100; a_wdata = 8'h11; b_req = 1; b_we = 0; b_addr = 12'h200;
    na = 0; nacks = 0; a_before = -1;
    for (int i = 0; i < 100 && nacks < 6; i++) begin
      @(negedge clk);
      if (b_ack) begin b_req = 0; a_before = na; nacks++; end
      if (a_ack) begin na++; nacks++; if (nacks == 6) a_req = 0; end
    end
    a_req = 0; b_req = 0;
    chk("t3_a_before_b", a_before, 4);
    chk("t3_a_total", na, 5);
    chk("t3_b_data", b_rdata, 8'hA5);
    repeat (4) @(negedge clk);
    // fill with pending A request and an ignored restart
    clr_start = 1; clr_value = 8'hFF;
    chk("t4_busy_pre", clr_busy, 0);
    @(negedge clk);
    clr_start = 0; a_req = 1; a_we = 0; a_addr = 12'hFFF;
    n = 0; k = 0; bad = 0;
    while (clr_busy && k < 5000) begin
      n++;
      if (a_ack) bad++;
      if (n == 1000) begin clr_start = 1; clr_value = 8'h77; end else clr_start = 0;
      @(negedge clk);
      k++;
    end
    clr_start = 0;
    chk("t4_busy_cycles", n, 4096);
    chk("t4_ack_during_fill", bad, 0);
    k = 0;
    while (!a_ack && k < 10) begin @(negedge clk); k++; end
    chk("t4_ack_seen", a_ack, 1);
    chk("t4_rdata", a_rdata, 8'hFF);
    a_req = 0;
    // reset in the middle of a fill
    @(negedge clk);
    op(0, 1, 12'hFFF, 8'h3C, lat, rd);
    @(negedge clk) begin clr_start = 1; clr_value = 8'hFF; end
    @(negedge clk) clr_start = 0;
    repeat (2000) @(negedge clk);
    chk("t5_busy_mid", clr_busy, 1);
    @(posedge clk); #2 reset_n = 0;
    #1 reset_zero("t5");
    @(negedge clk);
    @(negedge clk) reset_n = 1;
    @(negedge clk);
    op(0, 0, 12'h000, 8'h00, lat, rd);
    chk("t5_lat", lat, 3);
    chk("t5_rd0", rd, 8'hFF);
    @(negedge clk);
    op(0, 0, 12'hFFF, 8'h00, lat, rd);
    chk("t5_rdfff", rd, 8'h3C);
    // B write immediately followed by B read of the same word
    @(negedge clk);
    op(1, 1, 12'h345, 8'hC3, lat, rd);
    chk("t6_wr_lat", lat, 2);
    op(1, 0, 12'h345, 8'h00, lat, rd);
    chk("t6_b2b_lat", lat, 4);
    chk("t6_rd", rd, 8'hC3);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Two-requester arbiter and sequencer for the 8-bit × 4K single-port block RAM used as shared work/video memory. Port A (CPU bus side, normally high priority) and port B (display/DMA side) each issue single-beat read/write requests. The block serialises them onto the RAM's CE/WRE/AD/DIN/DOUT pins and returns read data with a one-cycle acknowledge pulse. It also provides a hardware fill (clear) of the whole RAM after reset or on command.

## Interface
- `AW`, 12: RAM address width (4096 words).
- `DW`, 8: RAM data width.
- `STARVE_LIMIT`, 4: consecutive A grants while B is waiting before B is forced to win; range 1..15.
- `clk`  in  1  single clock for arbiter and RAM.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_req`, `b_req`  in  1  request, level, held until matching ack.
- `a_we`, `b_we`  in  1  1 = write, 0 = read; stable while req high.
- `a_addr`, `b_addr`  in  AW  word address; stable while req high.
- `a_wdata`, `b_wdata`  in  DW  write data.
- `a_ack`, `b_ack`  out  1  one-cycle completion pulse.
- `a_rdata`, `b_rdata`  out  DW  read data, valid in the ack cycle, held until the next ack on that port.
- `clr_start`  in  1  pulse, starts a fill of all words with `clr_value`.
- `clr_value`  in  DW  fill byte, sampled on `clr_start`.
- `clr_busy`  out  1  high throughout a fill.
- `ram_ce`, `ram_wre`  out  1  RAM clock enable / write enable.
- `ram_oce`  out  1  constant 1.
- `ram_reset`  out  1  constant 0.
- `ram_ad`  out  AW  RAM address.
- `ram_din`  out  DW  RAM write data.
- `ram_dout`  in  DW  RAM read data, valid one clock after the address edge (bypass read mode).

## Operation
- FSM states: IDLE, ISSUE, RDWAIT, ACK, CLEAR.
- **IDLE**
  - `clr_start` has top precedence: latch the fill byte, set the clear counter to 0, go to CLEAR.
  - Otherwise, if any request is pending, pick a winner, register its we/addr/wdata onto the ram_* registers, and go to ISSUE.
- **Arbitration**
  - A wins over B unless the starvation counter equals `STARVE_LIMIT`.
  - The starvation counter increments (saturating) on each A grant while `b_req` is high.
  - It clears on any B grant.
- **ISSUE**: `ram_ce`=1 and `ram_wre`=we for exactly one cycle. For a write, go to ACK; for a read, go to RDWAIT.
- **RDWAIT**: capture `ram_dout` into the winner's rdata register; go to ACK.
- **ACK**: pulse the winner's ack; go to IDLE. The requester must deassert req, or present a new request, by the end of the ack cycle.
- **CLEAR**
  - Writes `clr_value` at addresses 0..4095, one per cycle (`ram_ce`=`ram_wre`=1).
  - Leaves after address 4095 is written, then returns to IDLE.
  - Requests stay pending, with no ack, until the fill ends.
  - `clr_start` during CLEAR is ignored.
- The fill counter is AW+1 bits wide. Termination is when bit AW sets, so there is no wrap-around rewrite.
- Outside ISSUE and CLEAR, `ram_ce`=0 and `ram_wre`=0. `ram_ad` and `ram_din` hold their last value.

## Timing
- Reset values: all acks 0, rdata 0, `ram_ce`/`ram_wre` 0, `ram_ad`/`ram_din` 0, `clr_busy` 0, starvation counter 0, state IDLE.
- Read: req sampled at cycle 0 → ISSUE at cycle 1 → capture at cycle 2 → ack at cycle 3. Latency 3, one read per 4 cycles.
- Write: req sampled at cycle 0 → ISSUE at cycle 1 → ack at cycle 2. One write per 3 cycles.
- If both requests rise in the same cycle, A is served first. B is granted in the IDLE cycle directly after A's ack.
- `clr_busy` rises in the cycle after `clr_start` and falls in the cycle after the last fill write. A fill occupies 4096 cycles plus 1 exit cycle.
- When `reset_n` is asserted mid-transaction or mid-fill, all outputs go to reset values immediately. No ack is issued and the fill is abandoned part-way.

## Structure
- Shared package `sp_ram_arb_pkg` holds:
  - the FSM state enum;
  - `RAM_AW`=12 and `RAM_DW`=8;
  - a requester-id type {REQ_A, REQ_B}.
- Single module. No sub-module is warranted; the RAM primitive is instantiated at the level above.

## Test plan
- Reset, then A writes 0x5A to 0x123 and later reads it back → `a_ack` arrives 2 cycles after the write request and 3 cycles after the read request, with `a_rdata`=0x5A.
- `a_req` and `b_req` rise together (A reads 0x010, B reads 0x020) → A is acked first, B is acked 4 cycles later, and each gets its own data.
- A requests continuously while B is held, with `STARVE_LIMIT`=4 → exactly 4 A acks, then 1 B ack, then A resumes.
- `clr_start` with `clr_value`=0xFF, with `a_req` asserted in the next cycle → `clr_busy` is high for 4096 cycles and no `a_ack` arrives meanwhile. A's read of 0xFFF then returns 0xFF.
- `reset_n` pulsed low while at word 2000 of the fill → all outputs drop to 0 asynchronously. A read of 0x000 after release returns 0xFF and a read of 0xFFF returns the pre-fill content.
- B write immediately followed by B read at the same address → the read returns the new value, with no stale data.
